fpu_config_responder: RTL and testbench



---
 rtl/fpu_cfg_pkg.sv | 47 ++++
 rtl/fpu_cfg_regs.sv | 94 +++++++++
 rtl/fpu_config_responder.sv | 139 +++++++++++++
 tb/tb_fpu_config_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fpu_cfg_pkg
//   Shared definitions for the FPU filter-engine configuration responder:
//   byte offsets of the config words, CTRL bit positions, word indices used
//   by the register file, the responder state enum and the address decoder.
// -----------------------------------------------------------------------------
package fpu_cfg_pkg;

    // Byte offsets from BASE_ADDR
    localparam logic [31:0] CFG_FILT0_OFF  = 32'h00;
    localparam logic [31:0] CFG_FILT1_OFF  = 32'h04;
    localparam logic [31:0] CFG_FILT2_OFF  = 32'h08;
    localparam logic [31:0] CFG_GEOM_OFF   = 32'h0C;
    localparam logic [31:0] CFG_START_OFF  = 32'h10;
    localparam logic [31:0] CFG_RESULT_OFF = 32'h14;
    localparam logic [31:0] CFG_CTRL_OFF   = 32'h18;

    // Word indices (offset >> 2); NONE marks an unmapped address
    localparam int          CFG_NUM_WORDS  = 6;
    localparam logic [2:0]  CFG_IDX_FILT2  = 3'(CFG_FILT2_OFF >> 2);
    localparam logic [2:0]  CFG_IDX_CTRL   = 3'(CFG_CTRL_OFF >> 2);
    localparam logic [2:0]  CFG_IDX_NONE   = 3'd7;

    // CTRL bit positions
    localparam int CTRL_GO_BIT   = 0;
    localparam int CTRL_BUSY_BIT = 1;
    localparam int CTRL_DONE_BIT = 2;
    localparam int CTRL_ERR_BIT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } fpu_cfg_state_t;

    // Map a byte address to a word index. Everything outside the seven-word
    // window (including 0x1C, which lands on index 7) decodes to NONE.
    function automatic logic [2:0] cfg_decode(input logic [31:0] addr,
                                              input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        if (off[31:5] == 27'd0 && off[1:0] == 2'b00)
            return off[4:2];
        return CFG_IDX_NONE;
    endfunction

endpackage

// File: rtl/fpu_cfg_regs.sv
// -----------------------------------------------------------------------------
// fpu_cfg_regs
//   Six-word configuration register file with one write port and two
//   independent registered read ports (CPU side and loader side).
//   Index 6 (CTRL) is not stored here: it reads ctrl_word_i so that both
//   ports see the same word map. Unmapped indices read as 0.
//   Read data holds its last value when no read is issued.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   wr_en_i           write strobe (index already known to be 0..5)
//   wr_idx_i/data_i   write word index and data
//   ctrl_word_i       current CTRL value, returned for index 6
//   cpu_rd_en_i/idx_i CPU read request and word index
//   cpu_rdata_o/valid CPU read data, one cycle after the request
//   ldr_rd_en_i/idx_i loader read request and word index
//   ldr_rdata_o/valid loader read data, one cycle after the request
// -----------------------------------------------------------------------------
module fpu_cfg_regs
    import fpu_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] ctrl_word_i,
    input  logic        cpu_rd_en_i,
    input  logic [2:0]  cpu_rd_idx_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_rvalid_o,
    input  logic        ldr_rd_en_i,
    input  logic [2:0]  ldr_rd_idx_i,
    output logic [31:0] ldr_rdata_o,
    output logic        ldr_rvalid_o
);

    logic [31:0] word_q [CFG_NUM_WORDS];
    logic [31:0] cpu_rdata_q, ldr_rdata_q;
    logic        cpu_rvalid_q, ldr_rvalid_q;
    logic [31:0] cpu_rdata_d, ldr_rdata_d;

    function automatic logic [31:0] read_word(input logic [2:0] idx);
        logic [31:0] w;
        w = '0;
        if (idx == CFG_IDX_CTRL)
            w = ctrl_word_i;
        else if (idx < CFG_IDX_CTRL)
            w = word_q[idx];
        return w;
    endfunction

    // Filter tap 8 is a single byte; the upper bits are never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CFG_NUM_WORDS; i++)
                word_q[i] <= '0;
        end else if (wr_en_i) begin
            if (wr_idx_i == CFG_IDX_FILT2)
                word_q[wr_idx_i] <= {24'd0, wr_data_i[7:0]};
            else
                word_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        if (cpu_rd_en_i)
            cpu_rdata_d = read_word(cpu_rd_idx_i);
        if (ldr_rd_en_i)
            ldr_rdata_d = read_word(ldr_rd_idx_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            ldr_rdata_q  <= '0;
            ldr_rvalid_q <= 1'b0;
        end else begin
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rd_en_i;
            ldr_rdata_q  <= ldr_rdata_d;
            ldr_rvalid_q <= ldr_rd_en_i;
        end
    end

    assign cpu_rdata_o  = cpu_rdata_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign ldr_rdata_o  = ldr_rdata_q;
    assign ldr_rvalid_o = ldr_rvalid_q;

endmodule

// File: rtl/fpu_config_responder.sv
// -----------------------------------------------------------------------------
// fpu_config_responder
//   CPU-programmable configuration store for the FPU filter engine. A GO
//   write to CTRL pulses load_config_start for one cycle; busy then stays
//   high until the loader reports load_config_done, which sets the sticky
//   DONE bit. Loader word reads are answered with one cycle of latency in
//   every state.
//
//   Optional feature (macro FPU_CFG_WRITE_LOCK_EN): while a load is in
//   progress (START or BUSY) CPU writes to config words are dropped and set
//   the sticky CTRL.ERR bit. Without the macro such writes land normally and
//   ERR always reads 0.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   cpu_wr_en/cpu_addr/cpu_wdata      CPU write port
//   cpu_rd_en -> cpu_rdata/_valid     CPU read port, 1-cycle latency
//   mem_req/address_mem -> data_mem/mapped_data_valid
//                                     loader read port, 1-cycle latency
//   load_config_start                 one-cycle start pulse to the loader
//   load_config_done                  completion pulse from the loader
//   busy                              load in progress
// -----------------------------------------------------------------------------
module fpu_config_responder
    import fpu_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr_en,
    input  logic        cpu_rd_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdata_valid,
    input  logic        mem_req,
    input  logic [31:0] address_mem,
    output logic [31:0] data_mem,
    output logic        mapped_data_valid,
    output logic        load_config_start,
    input  logic        load_config_done,
    output logic        busy
);

    fpu_cfg_state_t state_q, state_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [2:0]  cpu_idx, ldr_idx;
    logic        cfg_wr, ctrl_wr, reg_we, dropped_wr, go, done_evt;
    logic [31:0] ctrl_word;

    assign cpu_idx  = cfg_decode(cpu_addr, BASE_ADDR);
    assign ldr_idx  = cfg_decode(address_mem, BASE_ADDR);

    assign cfg_wr   = cpu_wr_en && (cpu_idx < CFG_IDX_CTRL);
    assign ctrl_wr  = cpu_wr_en && (cpu_idx == CFG_IDX_CTRL);
    assign go       = ctrl_wr && cpu_wdata[CTRL_GO_BIT];
    assign done_evt = (state_q == BUSY) && load_config_done;

`ifdef FPU_CFG_WRITE_LOCK_EN
    logic locked;
    assign locked     = (state_q != IDLE);
    assign reg_we     = cfg_wr && !locked;
    assign dropped_wr = cfg_wr && locked;
`else
    assign reg_we     = cfg_wr;
    assign dropped_wr = 1'b0;
`endif

    // GO reads as 0; BUSY mirrors the busy output.
    assign ctrl_word = {28'd0, err_q, done_q, (state_q == BUSY), 1'b0};

    // A completion and a write-1-to-clear in the same cycle leave DONE set:
    // the completion is the newer event. ERR follows the same rule.
    always_comb begin
        done_d = done_q;
        if (ctrl_wr && cpu_wdata[CTRL_DONE_BIT])
            done_d = 1'b0;
        if (done_evt)
            done_d = 1'b1;
    end

`ifdef FPU_CFG_WRITE_LOCK_EN
    always_comb begin
        err_d = err_q;
        if (ctrl_wr && cpu_wdata[CTRL_ERR_BIT])
            err_d = 1'b0;
        if (dropped_wr)
            err_d = 1'b1;
    end
`else
    assign err_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (load_config_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign load_config_start = (state_q == START);
    assign busy              = (state_q == BUSY);

    fpu_cfg_regs u_regs (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (reg_we),
        .wr_idx_i     (cpu_idx),
        .wr_data_i    (cpu_wdata),
        .ctrl_word_i  (ctrl_word),
        .cpu_rd_en_i  (cpu_rd_en),
        .cpu_rd_idx_i (cpu_idx),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rdata_valid),
        .ldr_rd_en_i  (mem_req),
        .ldr_rd_idx_i (ldr_idx),
        .ldr_rdata_o  (data_mem),
        .ldr_rvalid_o (mapped_data_valid)
    );

endmodule

// File: tb/tb_fpu_config_responder.sv
module tb_fpu_config_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] CTRL = BASE + 32'h18;
`ifdef FPU_CFG_WRITE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_wr_en = 1'b0, cpu_rd_en = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_rdata_valid;
    logic        mem_req = 1'b0;
    logic [31:0] address_mem = '0;
    logic [31:0] data_mem;
    logic        mapped_data_valid;
    logic        load_config_start;
    logic        load_config_done = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    fpu_config_responder #(.BASE_ADDR(BASE)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_wr_en         (cpu_wr_en),
        .cpu_rd_en         (cpu_rd_en),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_rdata_valid   (cpu_rdata_valid),
        .mem_req           (mem_req),
        .address_mem       (address_mem),
        .data_mem          (data_mem),
        .mapped_data_valid (mapped_data_valid),
        .load_config_start (load_config_start),
        .load_config_done  (load_config_done),
        .busy              (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: config memory, sticky flags and the load phase
    // (0 = idle, 1 = start pulse, 2 = waiting for the loader).
    // ------------------------------------------------------------------
    logic [31:0] m_word [6];
    bit          m_done, m_err;
    int          m_phase;
    bit          exp_start, exp_busy;
    logic [31:0] lq[$];
    logic [31:0] cq[$];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off == 32'h18)
            return {28'd0, m_err, m_done, (m_phase == 2), 1'b0};
        if (off < 32'h18 && off[1:0] == 2'b00)
            return m_word[off[4:2]];
        return 32'd0;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] coff;
        bit          go, fin;
        if (rst) begin
            for (int i = 0; i < 6; i++) m_word[i] = '0;
            m_done = 0; m_err = 0; m_phase = 0;
            exp_start = 0; exp_busy = 0;
            lq.delete(); cq.delete();
        end else begin
            if (mem_req)   lq.push_back(m_read(address_mem));
            if (cpu_rd_en) cq.push_back(m_read(cpu_addr));
            coff = cpu_addr - BASE;
            fin  = (m_phase == 2) && load_config_done;
            go   = 0;
            if (cpu_wr_en) begin
                if (coff < 32'h18 && coff[1:0] == 2'b00) begin
                    if (LOCK && m_phase != 0)
                        m_err = 1;
                    else
                        m_word[coff[4:2]] = (coff == 32'h08) ? (cpu_wdata & 32'hFF) : cpu_wdata;
                end else if (coff == 32'h18) begin
                    if (cpu_wdata[2]) m_done = 0;
                    if (cpu_wdata[3]) m_err  = 0;
                    go = cpu_wdata[0] && (m_phase == 0);
                end
            end
            if (fin) m_done = 1;
            if (m_phase == 0 && go)       m_phase = 1;
            else if (m_phase == 1)        m_phase = 2;
            else if (fin)                 m_phase = 0;
            exp_start = (m_phase == 1);
            exp_busy  = (m_phase == 2);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares every cycle on the falling edge.
    // ------------------------------------------------------------------
    logic [31:0] last_l, last_c;

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst) begin
            last_l = '0;
            last_c = '0;
        end else begin
            chk("start_pulse", 32'(load_config_start), 32'(exp_start));
            chk("busy", 32'(busy), 32'(exp_busy));

            chk("ldr_valid", 32'(mapped_data_valid), 32'(lq.size() != 0));
            if (lq.size() != 0) begin
                e = lq.pop_front();
                if (mapped_data_valid) chk("ldr_data", data_mem, e);
                last_l = e;
            end else begin
                chk("ldr_hold", data_mem, last_l);
            end

            chk("cpu_valid", 32'(cpu_rdata_valid), 32'(cq.size() != 0));
            if (cq.size() != 0) begin
                e = cq.pop_front();
                if (cpu_rdata_valid) chk("cpu_data", cpu_rdata, e);
                last_c = e;
            end else begin
                chk("cpu_hold", cpu_rdata, last_c);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        cpu_wr_en = 0; cpu_rd_en = 0; mem_req = 0; load_config_done = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_wr_en = 1; cpu_addr = a; cpu_wdata = d;
        step();
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        cpu_rd_en = 1; cpu_addr = a;
        step();
        #1;
        chk(name, cpu_rdata, exp);
    endtask

    task automatic ldr(input string name, input logic [31:0] a, input logic [31:0] exp);
        mem_req = 1; address_mem = a;
        step();
        #1;
        chk(name, data_mem, exp);
        chk({name, "_valid"}, 32'(mapped_data_valid), 32'd1);
    endtask

    task automatic outputs_zero(input string name);
        chk({name, "_start"}, 32'(load_config_start), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_ldr_valid"}, 32'(mapped_data_valid), 32'd0);
        chk({name, "_data_mem"}, data_mem, 32'd0);
        chk({name, "_cpu_valid"}, 32'(cpu_rdata_valid), 32'd0);
        chk({name, "_cpu_rdata"}, cpu_rdata, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] seq_a [3];
        logic [31:0] seq_e [3];
        logic [31:0] offs [9];

        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset");
        rst = 0;
        step();

        // Program and read back through the loader, back-to-back
        wr(BASE + 32'h00, 32'h0403_0201);
        wr(BASE + 32'h0C, 32'h01E0_0280);
        wr(BASE + 32'h10, 32'h2000_0000);
        wr(BASE + 32'h14, 32'h1111_2222);
        seq_a = '{BASE + 32'h00, BASE + 32'h0C, BASE + 32'h10};
        seq_e = '{32'h0403_0201, 32'h01E0_0280, 32'h2000_0000};
        for (int i = 0; i < 3; i++) begin
            mem_req = 1; address_mem = seq_a[i];
            @(posedge clk);
            #2;
            chk("b2b_data", data_mem, seq_e[i]);
            chk("b2b_valid", 32'(mapped_data_valid), 32'd1);
        end
        mem_req = 0;
        step();

        // Tap 8 keeps only its low byte
        wr(BASE + 32'h08, 32'hDEAD_BEEF);
        rd("filt2_mask", BASE + 32'h08, 32'h0000_00EF);

        // GO timing, GO during BUSY, completion, DONE clear
        wr(CTRL, 32'h1);
        chk("go_start", 32'(load_config_start), 32'd1);
        chk("go_busy_early", 32'(busy), 32'd0);
        step();
        chk("go_start_once", 32'(load_config_start), 32'd0);
        chk("go_busy", 32'(busy), 32'd1);
        wr(CTRL, 32'h1);
        step();
        chk("go_in_busy_nostart", 32'(load_config_start), 32'd0);
        rd("ctrl_busy", CTRL, 32'h2);
        load_config_done = 1;
        step();
        chk("done_busy_low", 32'(busy), 32'd0);
        rd("ctrl_done", CTRL, 32'h4);
        wr(CTRL, 32'h4);
        rd("ctrl_cleared", CTRL, 32'h0);

        // Second run: GO together with DONE clear after a completion
        wr(CTRL, 32'h1);
        step();
        load_config_done = 1;
        step();
        wr(CTRL, 32'h5);
        chk("go2_start", 32'(load_config_start), 32'd1);
        step();
        rd("ctrl_go_clr", CTRL, 32'h2);

        // Config write while busy
        wr(BASE + 32'h14, 32'h3333_4444);
        rd("lock_word", BASE + 32'h14, LOCK ? 32'h1111_2222 : 32'h3333_4444);
        rd("lock_err", CTRL, LOCK ? 32'hA : 32'h2);
        load_config_done = 1;
        step();
        wr(CTRL, 32'hC);
        rd("ctrl_clear_all", CTRL, 32'h0);

        // Unmapped loader read, and read/write collision
        ldr("ldr_unmapped", BASE + 32'h40, 32'h0);
        cpu_wr_en = 1; cpu_addr = BASE + 32'h10; cpu_wdata = 32'h5555_6666;
        mem_req = 1; address_mem = BASE + 32'h10;
        step();
        #1;
        chk("collide_old", data_mem, 32'h2000_0000);
        ldr("collide_new", BASE + 32'h10, 32'h5555_6666);

        // Reset in the middle of a load
        wr(CTRL, 32'h1);
        step();
        mem_req = 1; address_mem = BASE;
        step();
        rst = 1;
        #1;
        outputs_zero("midrst");
        @(posedge clk);
        #1;
        rst = 0;
        step();
        chk("post_rst_nostart", 32'(load_config_start), 32'd0);
        ldr("post_rst_word0", BASE, 32'h0);

        // Random traffic against the model
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h40};
        for (int n = 0; n < 600; n++) begin
            cpu_wr_en   = ($urandom_range(0, 3) == 0);
            cpu_rd_en   = ($urandom_range(0, 2) == 0);
            cpu_addr    = BASE + offs[$urandom_range(0, 8)];
            cpu_wdata   = $urandom;
            if (cpu_addr == CTRL && $urandom_range(0, 1) == 1)
                cpu_wdata[0] = 1'b1;
            mem_req     = $urandom_range(0, 1) == 1;
            address_mem = ($urandom_range(0, 15) == 0) ? $urandom : BASE + offs[$urandom_range(0, 8)];
            load_config_done = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        cpu_wr_en = 0; cpu_rd_en = 0; mem_req = 0; load_config_done = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
